// File: rtl/inverse_zigzag.sv
// Purpose : scatters 64 zigzag-ordered signed coefficients into an 8x8 raster block, presented packed on A.
// Latency : out_valid rises the cycle after beat 63 is accepted (64 cycles minimum from beat 0).
// Backpressure: in_ready drops while a full block waits; out_ack releases it and loading resumes next cycle.
//
// Ports:
//   Clock, reset     - rising-edge clock, asynchronous active-high reset
//   restart          - synchronous clear of the block in progress (buffer contents kept)
//   in_data/in_valid - coefficient stream in zigzag order; in_ready is high while loading
//   A/out_valid      - packed raster block, element (i,j) at A[(i*8+j)*COEF_W +: COEF_W]
//   out_ack          - downstream consumed the block
//   coef_cnt         - beats accepted in the current block (0..64)
module inverse_zigzag #(
  parameter int COEF_W = 8
) (
  input  logic                     Clock,
  input  logic                     reset,
  input  logic                     restart,
  input  logic signed [COEF_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [64*COEF_W-1:0]     A,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [6:0]               coef_cnt
);

  typedef enum logic [0:0] {LOAD, FULL} state_t;

  state_t            state_q;
  logic [6:0]        cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [COEF_W-1:0] buf_q [64];

  // Zigzag scan index -> raster position.
  function automatic logic [5:0] zz(input logic [5:0] k);
    logic [5:0] r;
    r = 6'd0;
    case (k)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // restart outranks everything; a beat coinciding with it is dropped.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= 7'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 64; i++) buf_q[i] <= '0;
    end else if (restart) begin
      state_q     <= LOAD;
      cnt_q       <= 7'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            buf_q[zz(cnt_q[5:0])] <= in_data;
            cnt_q                 <= cnt_q + 7'd1;
            if (cnt_q == 7'd63) begin
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ack) begin
            state_q     <= LOAD;
            cnt_q       <= 7'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOAD;
          cnt_q       <= 7'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    A = '0;
    for (int i = 0; i < 64; i++) A[i*COEF_W +: COEF_W] = buf_q[i];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign coef_cnt  = cnt_q;

endmodule

// File: doc/inverse_zigzag.md
# inverse_zigzag

Serial-to-block stage that sits directly upstream of the dequantization stage in the JPEG decode path. It accepts 64 signed 8-bit quantized coefficients, one per beat, in JPEG zigzag order. It scatters them into raster (row-major) positions of an 8x8 buffer and presents the completed block as a 512-bit packed word. The output handshake is shaped to drive the dequantizer's Enable/done pair directly.

## Interface
- COEF_W, 8, coefficient width in bits (signed, two's complement); block output width is 64*COEF_W
- Clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- restart  input  1  synchronous clear; drops any partial block and returns to LOAD
- in_data  input  COEF_W  signed coefficient, zigzag order
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  block can accept a beat this cycle
- A  output  64*COEF_W  packed raster block; element (row i, col j) at A[(i*8+j)*COEF_W +: COEF_W]
- out_valid  output  1  A holds a complete block; connect to downstream Enable
- out_ack  input  1  downstream consumed the block (connect downstream done)
- coef_cnt  output  7  beats accepted in current block (0..64)

## Operation
- Two states: LOAD and FULL. Reset state is LOAD.
- LOAD:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - The beat writes buf[zz(k)] = in_data, where k = coef_cnt (0..63), then coef_cnt increments.
  - If the accepted beat has k==63, go to FULL.
- FULL:
  - in_ready=0, out_valid=1.
  - A is stable and holds the packed buffer.
  - in_valid is ignored and no beat is accepted.
  - When out_ack==1, go to LOAD and set coef_cnt to 0.
- zz(k) is the standard JPEG zigzag-to-raster map, held in a 64-entry constant LUT:
  - 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63
- A is a direct packing of the buffer registers. No arithmetic is performed and values pass bit-exact (sign preserved).
- The buffer is not cleared between blocks, because all 64 positions are overwritten each block. During LOAD, A shows partially updated contents and is don't-care while out_valid=0.
- restart:
  - Has priority over every other synchronous event.
  - Sets state to LOAD and coef_cnt to 0.
  - Buffer contents are left untouched.
  - A beat presented in the same cycle as restart is not accepted; it is not written and not counted.
- A beat presented while in FULL is not written and not counted.
- out_ack asserted during LOAD is ignored.

## Timing
- Reset values:
  - state=LOAD, coef_cnt=0, out_valid=0.
  - in_ready=1; it is asserted immediately on reset deassertion.
  - A=0, because all buffer entries are reset to 0.
- Throughput in LOAD is one beat per cycle. Gaps are allowed: cycles with in_valid=0 change nothing.
- out_valid rises in the cycle after the edge that accepts beat 63. Minimum latency from beat 0 to out_valid is 64 cycles.
- out_ack sampled high in FULL:
  - out_valid falls and in_ready rises at the next edge.
  - The first beat of the next block can be accepted in that following cycle.
  - Minimum block period is 65 cycles plus the downstream latency to out_ack.
- out_valid and in_ready are registered or state-decoded, so there is no combinational path from in_valid or out_ack to in_ready or out_valid.
- Reset asserted mid-block, or while FULL, takes effect immediately: all outputs return to their reset values and the partial block is lost.

## Test plan
- Ramp block:
  - Stimulus: reset, then stream in_data = k for k = 0..63 back-to-back.
  - Required: out_valid=1 exactly 64 cycles after the first beat.
  - Check element (0,0)=0, (0,1)=1, (1,0)=2, (2,0)=3, (7,7)=63, (7,6)=62, (6,7)=61.
  - Check in_ready=0 until out_ack.
- Sign preservation:
  - Stimulus: in_data = -128 (0x80) at k=0, -1 (0xFF) at k=63, 0 elsewhere.
  - Required: A[7:0]=0x80, A[511:504]=0xFF, all other bytes 0.
- Backpressure:
  - Stimulus: hold in_valid=1 with 20 extra beats while FULL, then pulse out_ack for one cycle.
  - Required: A unchanged throughout FULL; coef_cnt=64 while FULL; coef_cnt=0 and in_ready=1 the cycle after out_ack.
  - Required: the next block loads correctly from beat 0.
- Gapped input:
  - Stimulus: in_valid toggled pseudo-randomly over 64 accepted beats.
  - Required: same A as the back-to-back ramp; coef_cnt advances only on accepted beats.
- restart mid-block:
  - Stimulus: accept 30 beats, assert restart together with in_valid=1, then send a fresh full ramp.
  - Required: coef_cnt=0 after restart; the beat in the restart cycle is dropped; the final A equals the ramp result.
- Async reset while FULL:
  - Stimulus: assert reset between clock edges while FULL.
  - Required: out_valid=0, in_ready=1, coef_cnt=0 and A=0 immediately, without waiting for a clock edge.
